// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes and FSM states shared by alu_seq and the ALU control unit
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_MUL  = 4'd10
    } alu_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between an ALU requester (master) and alu_seq (slave)
interface alu_seq_if #(
    parameter int DATA_W = 32
) ();

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        ALUType;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;

    modport master (
        output in_valid, ALUType, src1, src2, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, ALUType, src1, src2, out_ready,
        output in_ready, out_valid, result, zero
    );

endinterface

// File: rtl/alu_seq_shift.sv
// alu_seq_shift: one iteration of the shift (and, with ALU_SEQ_MUL_EN, shift-add multiply) datapath
module alu_seq_shift
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
`ifdef ALU_SEQ_MUL_EN
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_acc,
    output logic [DATA_W-1:0] o_b,
    output logic [DATA_W-1:0] o_acc,
`endif
    output logic [DATA_W-1:0] o_a
);

    // Move the working operand one bit; SRA keeps the sign bit, SLL and MUL shift the multiplicand left
    always_comb begin
        o_a = (i_op == ALU_SRL) ? {1'b0, i_a[DATA_W-1:1]} :
              (i_op == ALU_SRA) ? {i_a[DATA_W-1], i_a[DATA_W-1:1]} :
                                  {i_a[DATA_W-2:0], 1'b0};
`ifdef ALU_SEQ_MUL_EN
        o_b   = {1'b0, i_b[DATA_W-1:1]};
        o_acc = i_b[0] ? i_acc + i_a : i_acc;
`endif
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle logic ops, bit-serial shifts, optional multiply via ALU_SEQ_MUL_EN
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);

    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int CNT_W   = $clog2(DATA_W + 1);

    state_e            r_state;
    state_e            w_next;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_comb;
    logic [DATA_W-1:0] w_step_a;
    logic [DATA_W-1:0] w_final;
    logic [CNT_W-1:0]  w_cnt_init;
    logic [SHAMT_W-1:0] w_shamt;
    logic              w_accept;
    logic              w_iter;
    logic              w_last;
    logic              w_is_mul;
`ifdef ALU_SEQ_MUL_EN
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_step_b;
    logic [DATA_W-1:0] w_step_acc;
`endif

    assign w_shamt = bus.src2[SHAMT_W-1:0];
`ifdef ALU_SEQ_MUL_EN
    assign w_is_mul = bus.ALUType == ALU_MUL;
    assign w_final  = (r_op == ALU_MUL) ? w_step_acc : w_step_a;
`else
    assign w_is_mul = 1'b0;
    assign w_final  = w_step_a;
`endif
    assign w_iter     = w_is_mul || (is_shift(bus.ALUType) && (w_shamt != '0));
    assign w_cnt_init = w_is_mul ? CNT_W'(DATA_W) : CNT_W'(w_shamt);
    assign w_accept   = bus.in_valid && (r_state == ST_IDLE);
    assign w_last     = r_cnt == CNT_W'(1);
    assign bus.result = r_result;
    assign bus.zero   = r_zero;

    alu_seq_shift #(.DATA_W(DATA_W)) u_shift (
        .i_op  (r_op),
        .i_a   (r_a),
`ifdef ALU_SEQ_MUL_EN
        .i_b   (r_b),
        .i_acc (r_acc),
        .o_b   (w_step_b),
        .o_acc (w_step_acc),
`endif
        .o_a   (w_step_a)
    );

    // Single-cycle result; zero-amount shifts pass src1 through, unknown codes give 0
    always_comb begin
        w_comb = '0;
        case (bus.ALUType)
            ALU_ADD:                   w_comb = bus.src1 + bus.src2;
            ALU_SUB:                   w_comb = bus.src1 - bus.src2;
            ALU_SLT:                   w_comb = DATA_W'($signed(bus.src1) < $signed(bus.src2));
            ALU_SLTU:                  w_comb = DATA_W'(bus.src1 < bus.src2);
            ALU_XOR:                   w_comb = bus.src1 ^ bus.src2;
            ALU_OR:                    w_comb = bus.src1 | bus.src2;
            ALU_AND:                   w_comb = bus.src1 & bus.src2;
            ALU_SLL, ALU_SRL, ALU_SRA: w_comb = bus.src1;
            default:                   w_comb = '0;
        endcase
    end

    // Next state and handshake outputs; DONE never bypasses back to accepting in the same cycle
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = r_state == ST_IDLE;
        bus.out_valid = r_state == ST_DONE;
        case (r_state)
            ST_IDLE: w_next = bus.in_valid ? (w_iter ? ST_BUSY : ST_DONE) : ST_IDLE;
            ST_BUSY: w_next = w_last ? ST_DONE : ST_BUSY;
            ST_DONE: w_next = bus.out_ready ? ST_IDLE : ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Operand latch on accept, one iteration per BUSY cycle, result captured only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_b      <= '0;
            r_acc    <= '0;
`endif
        end else if (w_accept) begin
            r_op  <= bus.ALUType;
            r_a   <= bus.src1;
            r_cnt <= w_cnt_init;
`ifdef ALU_SEQ_MUL_EN
            r_b   <= bus.src2;
            r_acc <= '0;
`endif
            if (!w_iter) begin
                r_result <= w_comb;
                r_zero   <= w_comb == '0;
            end
        end else if (r_state == ST_BUSY) begin
            r_a   <= w_step_a;
            r_cnt <= r_cnt - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
            r_b   <= w_step_b;
            r_acc <= w_step_acc;
`endif
            if (w_last) begin
                r_result <= w_final;
                r_zero   <= w_final == '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized scoreboard bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rdy_mode = 1;
    bit   mon_en = 1'b0;
    bit   inflight = 1'b0;
    bit   prev_ov = 1'b0;

    alu_seq_if #(.DATA_W(32)) bus ();

    alu_seq #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int   n;
        n = int'(b[4:0]);
        r.lat = 1;
        r.res = '0;
        case (op)
            0: r.res = a + b;
            1: r.res = a - b;
            2: begin r.res = a << n; r.lat = n + 1; end
            3: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4: r.res = (a < b) ? 32'd1 : 32'd0;
            5: r.res = a ^ b;
            6: begin r.res = a >> n; r.lat = n + 1; end
            7: begin r.res = $signed(a) >>> n; r.lat = n + 1; end
            8: r.res = a | b;
            9: r.res = a & b;
`ifdef ALU_SEQ_MUL_EN
            10: begin r.res = a * b; r.lat = 33; end
`endif
            default: r.res = '0;
        endcase
        r.z = r.res == '0;
        return r;
    endfunction

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        @(posedge clk); #1;
        exp_q.push_back(model(op, a, b));
        bus.ALUType  = 4'(op);
        bus.src1     = a;
        bus.src2     = b;
        bus.in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            w++;
            if (w > 2000) begin
                chk(1'b0, "accept_timeout", 32'(w), 32'd0);
                bus.in_valid = 1'b0;
                void'(exp_q.pop_back());
                return;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.ALUType  = 4'($urandom);
        bus.src1     = $urandom;
        bus.src2     = $urandom;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Consumer side: random or forced out_ready
    always @(posedge clk) begin
        #1;
        bus.out_ready = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    end

    // Monitor: checks each presented result, its latency, hold stability and in_ready blocking
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (inflight && !bus.out_valid) chk(bus.in_ready == 1'b0, "busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid) begin
                chk(bus.in_ready == 1'b0, "done_in_ready", 32'(bus.in_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_out", bus.result, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk(bus.result == e.res, "result", bus.result, e.res);
                    chk(bus.zero == e.z, "zero", 32'(bus.zero), 32'(e.z));
                    if (!prev_ov) chk(cyc - acc_cyc == e.lat, "latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        inflight = 1'b0;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc  = cyc;
                inflight = 1'b1;
            end
            prev_ov = bus.out_valid && !bus.out_ready;
        end
    end

    initial begin
        int w;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.ALUType  = '0;
        bus.src1     = '0;
        bus.src2     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(bus.in_ready == 1'b1, "rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk(bus.out_valid == 1'b0, "rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk(bus.result == 32'd0, "rst_result", bus.result, 32'd0);
        chk(bus.zero == 1'b0, "rst_zero", 32'(bus.zero), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        rdy_mode = 1;
        issue(0, 32'h7FFF_FFFF, 32'd1);
        issue(7, 32'h8000_0000, 32'd4);
        drain();
        rdy_mode = 2;
        issue(1, 32'd5, 32'd5);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(bus.out_valid == 1'b1, "sub_out_valid", 32'(bus.out_valid), 32'd1);
        repeat (3) @(negedge clk);
        rdy_mode = 1;
        drain();
        @(negedge clk);
        chk(bus.in_ready == 1'b1, "ready_after_done", 32'(bus.in_ready), 32'd1);
        issue(3, 32'hFFFF_FFFF, 32'd1);
        issue(4, 32'hFFFF_FFFF, 32'd1);
        issue(10, 32'd6, 32'd7);
        issue(12, 32'h0000_ABCD, 32'd3);
        issue(2, 32'h0000_1234, 32'h0000_0020);
        issue(6, 32'h8000_0001, 32'd31);
        drain();
        rdy_mode = 0;
        repeat (200) begin
            issue(int'($urandom_range(0, 15)), $urandom, $urandom);
        end
        drain();
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk); #1;
        bus.ALUType  = 4'd2;
        bus.src1     = 32'd1;
        bus.src2     = 32'd31;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk(bus.in_ready == 1'b1, "pre_rst_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.ALUType  = 4'd0;
        bus.src1     = 32'd3;
        bus.src2     = 32'd4;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk(bus.out_valid == 1'b0, "busy_before_rst", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk(bus.out_valid == 1'b0, "post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk(bus.result == 32'd0, "post_rst_result", bus.result, 32'd0);
        chk(bus.zero == 1'b0, "post_rst_zero", 32'(bus.zero), 32'd0);
        chk(bus.in_ready == 1'b1, "post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; SHAMT_W = log2(DATA_W) (5 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 ALUType  input  4  operation code from the ALU control unit, per alu_pkg encoding.
REQ-007 src1  input  DATA_W  operand A.
REQ-008 src2  input  DATA_W  operand B; shifts use src2[SHAMT_W-1:0] as shamt.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  DATA_W  operation result.
REQ-012 zero  output  1  result == 0, valid with out_valid.

Function
REQ-013 FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 Accept on rising edge with in_valid && in_ready; ALUType, src1, src2 latched; later input changes ignored.
REQ-015 IDLE->DONE for ADD, SUB, SLT, SLTU, XOR, OR, AND, shifts with shamt 0, undefined codes; out_valid 1 cycle after accept.
REQ-016 IDLE->BUSY for SLL/SRL/SRA with shamt n>=1; one bit position per BUSY cycle; BUSY->DONE after n cycles; out_valid n+1 cycles after accept.
REQ-017 ADD/SUB wrap modulo 2^DATA_W; SLT signed, SLTU unsigned compare, result 1 or 0 zero-extended.
REQ-018 SRA replicates src1 sign bit each step; SRL/SLL fill with 0.
REQ-019 Undefined ALUType codes: result 0, zero 1, 1-cycle latency, no error flag.
REQ-020 DONE holds result and zero stable until out_ready high; DONE->IDLE on that edge.
REQ-021 No bypass: in_ready low in DONE even when out_ready high; next accept earliest the cycle after DONE exits.
REQ-022 result and zero change only on entry to DONE or reset.

Reset
REQ-023 rst high at an edge: state IDLE, result 0, zero 0, in-flight operation discarded, regardless of state.
REQ-024 rst overrides a same-cycle accept or out_ready; in_ready high first cycle after rst deasserts.

Configuration
REQ-025 ALU_SEQ_MUL_EN defined: ALUType MUL accepted; shift-add iterative multiply, one src2 bit per BUSY cycle, low DATA_W bits of product; out_valid DATA_W+1 cycles after accept.
REQ-026 ALU_SEQ_MUL_EN undefined: MUL treated as undefined code per REQ-019; no multiplier datapath synthesized.

Structure
REQ-027 Package alu_pkg holds ALUType enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, MUL=10; also FSM state typedef; shared with ALU control unit.
REQ-028 One sub-module alu_seq_shift: single-step shift/add datapath (one bit per call); FSM and handshake remain in alu_seq.

Verification
REQ-029 ADD src1=0x7FFFFFFF, src2=1, out_ready=1 -> out_valid 1 cycle after accept, result 0x80000000, zero 0.
REQ-030 SRA src1=0x80000000, src2=4 -> out_valid 5 cycles after accept, result 0xF8000000; in_ready low throughout.
REQ-031 SUB src1=5, src2=5, out_ready low 3 cycles -> result 0, zero 1 held stable; in_ready low until cycle after out_ready.
REQ-032 SLT src1=0xFFFFFFFF, src2=1 -> result 1; SLTU same operands -> result 0.
REQ-033 SLL src1=1, src2=31, rst pulsed at 10th cycle after accept -> next cycle IDLE, out_valid 0, result 0, in_ready 1.
REQ-034 MUL src1=6, src2=7: with ALU_SEQ_MUL_EN -> result 42 after 33 cycles; without -> result 0, zero 1, after 1 cycle.
